// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch key/display bundle.
// slave  : the stopwatch core (consumes keys, drives display signals)
// master : the board or bench side (drives keys, observes display signals)
interface stopwatch_ctrl_if;
    logic        key_ss_n;
    logic        key_clr_n;
    logic [15:0] bcd_out;
    logic [3:0]  dot_out;
    logic        clk_200Hz;
    logic        running;
    logic        overflow;

    modport slave (
        input  key_ss_n,
        input  key_clr_n,
        output bcd_out,
        output dot_out,
        output clk_200Hz,
        output running,
        output overflow
    );

    modport master (
        output key_ss_n,
        output key_clr_n,
        input  bcd_out,
        input  dot_out,
        input  clk_200Hz,
        input  running,
        input  overflow
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: SS.cc BCD count with start/stop and clear keys.
// Two pushbuttons are synchronised, debounced and edge-detected into
// one-cycle press events that drive an IDLE/RUN/PAUSE state machine.
// A free-running 200 Hz square wave is produced for the display scan.
//
// Optional feature: define STOPWATCH_SATURATE_EN to make the count stop at
// 99.99 (overflow set, RUN forced to PAUSE). Without it the count wraps to
// 00.00, sets overflow and keeps running.
module stopwatch_ctrl #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    stopwatch_ctrl_if.slave bus
);

    // Half period of the 200 Hz scan clock, in system clock cycles.
    localparam int                SCAN_HALF = CLK_HZ / 400;
    localparam int                SCAN_W    = (SCAN_HALF > 1) ? $clog2(SCAN_HALF) : 1;
    localparam logic [SCAN_W-1:0] SCAN_TC   = SCAN_W'(SCAN_HALF - 1);

    // Centisecond prescaler: counts 0 .. CLK_HZ/100-1.
    localparam int                 PRESC_N  = CLK_HZ / 100;
    localparam int                 PRESC_W  = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(PRESC_N - 1);

    // Debounce counter: counts consecutive disagreeing cycles, 0 .. DEBOUNCE_CYC-1.
    localparam int              DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [1:0]         w_key_n;     // raw keys, index 0 = start/stop, 1 = clear
    logic [1:0]         w_press;     // one-cycle press events, same indexing
    logic               w_ss;
    logic               w_clr;

    logic [SCAN_W-1:0]  r_scan_cnt;
    logic               r_clk_200hz;

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;

    logic [15:0]        r_bcd;
    logic [15:0]        w_bcd_inc;
    logic [15:0]        w_bcd_next;
    logic [4:0]         w_carry;     // w_carry[i] = increment reaching digit i
    logic               w_rollover;  // tick arriving while the count is 99.99

    logic               r_overflow;
    logic               w_overflow_next;
    logic               r_running;
    logic               w_running_next;
    logic               w_enter_idle;

    assign w_key_n = {bus.key_clr_n, bus.key_ss_n};

    //------------------------------------------------------------------
    // Key conditioning: synchroniser -> debouncer -> falling-edge detect
    //------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic            r_sync1;
            logic            r_sync2;
            logic            r_deb;
            logic            r_deb_d1;
            logic [DB_W-1:0] r_db_cnt;

            // Two-flop synchroniser; idles at the released level.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                end else begin
                    r_sync1 <= w_key_n[gi];
                    r_sync2 <= r_sync1;
                end
            end

            // Accept a new level only after it disagrees for DEBOUNCE_CYC cycles in a row.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_deb    <= 1'b1;
                    r_db_cnt <= '0;
                end else if (r_sync2 == r_deb) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == DB_TC) begin
                    r_deb    <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end

            // Delayed copy of the debounced level for press-edge detection.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_deb_d1 <= 1'b1;
                end else begin
                    r_deb_d1 <= r_deb;
                end
            end

            // High-to-low of the debounced level is a press; release is silent.
            assign w_press[gi] = r_deb_d1 & ~r_deb;
        end
    endgenerate

    assign w_ss  = w_press[0];
    assign w_clr = w_press[1];

    //------------------------------------------------------------------
    // Display scan clock: free-running in every state
    //------------------------------------------------------------------

    // Toggle the scan clock every CLK_HZ/400 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_clk_200hz <= 1'b0;
        end else if (r_scan_cnt == SCAN_TC) begin
            r_scan_cnt  <= '0;
            r_clk_200hz <= ~r_clk_200hz;
        end else begin
            r_scan_cnt  <= r_scan_cnt + SCAN_W'(1);
        end
    end

    //------------------------------------------------------------------
    // Centisecond prescaler: advances in RUN, holds in PAUSE, zero in IDLE
    //------------------------------------------------------------------

    // Keeping it at zero in IDLE makes every IDLE->RUN start on a fresh phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (r_state == S_IDLE) begin
            r_presc <= '0;
        end else if (r_state == S_RUN) begin
            r_presc <= (r_presc == PRESC_TC) ? '0 : r_presc + PRESC_W'(1);
        end
    end

    assign w_tick = (r_state == S_RUN) && (r_presc == PRESC_TC);

    //------------------------------------------------------------------
    // BCD incrementer: ripple carry across the four digits
    //------------------------------------------------------------------
    assign w_carry[0] = w_tick;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] w_dig;
            logic       w_dig_top;

            assign w_dig     = r_bcd[gi*4 +: 4];
            // ">= 9" rather than "== 9" so a corrupted digit still returns to 0.
            assign w_dig_top = (w_dig >= 4'd9);
            assign w_carry[gi+1]         = w_carry[gi] & w_dig_top;
            assign w_bcd_inc[gi*4 +: 4]  = !w_carry[gi] ? w_dig :
                                           (w_dig_top ? 4'd0 : w_dig + 4'd1);
        end
    endgenerate

    assign w_rollover = w_carry[4];

    //------------------------------------------------------------------
    // Control FSM
    //------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; clear wins over start/stop only in PAUSE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ss) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_ss) begin
                    w_state_next = S_PAUSE;
                end
`ifdef STOPWATCH_SATURATE_EN
                if (w_rollover) begin
                    w_state_next = S_PAUSE;
                end
`endif
            end
            S_PAUSE: begin
                if (w_clr) begin
                    w_state_next = S_IDLE;
                end else if (w_ss) begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output decode, computed from the next state so the registered copies line up with r_state.
    always_comb begin
        w_running_next = (w_state_next == S_RUN);
        w_enter_idle   = (r_state != S_IDLE) && (w_state_next == S_IDLE);
    end

    // Count and overflow next values; a tick in RUN and a return to IDLE never coincide.
    always_comb begin
        w_bcd_next      = r_bcd;
        w_overflow_next = r_overflow;
        if (w_enter_idle) begin
            w_bcd_next      = '0;
            w_overflow_next = 1'b0;
        end else if (w_tick) begin
            w_overflow_next = r_overflow | w_rollover;
`ifdef STOPWATCH_SATURATE_EN
            if (!w_rollover) begin
                w_bcd_next = w_bcd_inc;
            end
`else
            w_bcd_next = w_bcd_inc;
`endif
        end
    end

    // Registered count, overflow flag and running flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd      <= '0;
            r_overflow <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_bcd      <= w_bcd_next;
            r_overflow <= w_overflow_next;
            r_running  <= w_running_next;
        end
    end

    //------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------
    assign bus.bcd_out   = r_bcd;
    assign bus.dot_out   = 4'b1011;   // active-low point after d2: SS.cc
    assign bus.clk_200Hz = r_clk_200hz;
    assign bus.running   = r_running;
    assign bus.overflow  = r_overflow;

endmodule
